addr_window_map: RTL and testbench

Programmable, pipelined SNES-to-SRAM address translator. It replaces fixed per-mapper decode with NUM_WIN windows, each defined by base, mask, offset and attributes, all loaded by the MCU. Window sets are double-buffered: the MCU fills a shadow bank and commits it atomically between SNES lookups. Outputs feed the SRAM arbiter in place of combinational ROM_ADDR/ROM_HIT.

---
 rtl/addr_window_map_pkg.sv | 24 ++
 rtl/addr_window_prio.sv | 20 ++
 rtl/addr_window_map.sv | 143 ++++++++++++++
 tb/tb_addr_window_map.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/addr_window_map_pkg.sv
// Shared definitions for the programmable SNES-to-SRAM address window map:
// field select codes, attribute bit positions and the per-window record.
package addr_window_pkg;

  localparam int WIN_ADDR_W = 24;

  localparam logic [1:0] FLD_BASE   = 2'd0;
  localparam logic [1:0] FLD_MASK   = 2'd1;
  localparam logic [1:0] FLD_OFFSET = 2'd2;
  localparam logic [1:0] FLD_ATTR   = 2'd3;

  localparam int ATTR_EN   = 0;
  localparam int ATTR_ROM  = 1;
  localparam int ATTR_SRAM = 2;
  localparam int ATTR_WR   = 3;

  typedef struct packed {
    logic [WIN_ADDR_W-1:0] base;
    logic [WIN_ADDR_W-1:0] mask;
    logic [WIN_ADDR_W-1:0] offset;
    logic [3:0]            attr;
  } win_t;

endpackage

// File: rtl/addr_window_prio.sv
// Lowest-index-wins priority encoder over the per-window match vector.
module addr_window_prio #(
  parameter int NUM_WIN = 8,
  parameter int WIN_W   = 3
) (
  input  logic [NUM_WIN-1:0] match_vec,
  output logic               hit,
  output logic [WIN_W-1:0]   idx
);

  // Scanning downward lets the lowest matching index overwrite any higher one.
  always_comb begin
    hit = |match_vec;
    idx = '0;
    for (int i = NUM_WIN - 1; i >= 0; i--) begin
      if (match_vec[i]) idx = WIN_W'(i);
    end
  end

endmodule

// File: rtl/addr_window_map.sv
// Double-buffered window table plus a two-stage lookup pipeline translating
// SNES bus addresses into SRAM addresses with per-window attributes.
module addr_window_map
  import addr_window_pkg::*;
#(
  parameter int NUM_WIN = 8,
  parameter int ADDR_W  = WIN_ADDR_W,
  localparam int WIN_W  = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_sel,
  input  logic [1:0]        cfg_field,
  input  logic [ADDR_W-1:0] cfg_data,
  input  logic              cfg_commit,
  output logic              cfg_busy,
  input  logic              SNES_ADDR_VALID,
  input  logic [ADDR_W-1:0] SNES_ADDR,
  output logic [ADDR_W-1:0] ROM_ADDR,
  output logic              ROM_HIT,
  output logic              IS_ROM,
  output logic              IS_SAVERAM,
  output logic              IS_WRITABLE,
  output logic [WIN_W-1:0]  win_idx,
  output logic              out_valid,
  output logic [15:0]       miss_count
);

  win_t shadow_bank [NUM_WIN];
  win_t active_bank [NUM_WIN];

  logic               sel_ok;
  logic               copy_now;
  logic [NUM_WIN-1:0] match_vec;
  logic               s1_valid;
  logic [ADDR_W-1:0]  s1_addr;
  logic [NUM_WIN-1:0] s1_match;
  logic               prio_hit;
  logic [WIN_W-1:0]   prio_idx;
  win_t               win_sel;
  logic [ADDR_W-1:0]  xlat_addr;

  assign sel_ok = 32'(cfg_sel) < NUM_WIN;

  // The copy waits until no lookup is entering or sitting in stage 1, so
  // every in-flight lookup sees a single bank from match through translate.
  assign copy_now = cfg_busy && !SNES_ADDR_VALID && !s1_valid;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_WIN; i++) shadow_bank[i] <= '0;
    end else if (cfg_we && !cfg_busy && sel_ok) begin
      case (cfg_field)
        FLD_BASE:   shadow_bank[cfg_sel[WIN_W-1:0]].base   <= cfg_data;
        FLD_MASK:   shadow_bank[cfg_sel[WIN_W-1:0]].mask   <= cfg_data;
        FLD_OFFSET: shadow_bank[cfg_sel[WIN_W-1:0]].offset <= cfg_data;
        default:    shadow_bank[cfg_sel[WIN_W-1:0]].attr   <= cfg_data[3:0];
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cfg_busy <= 1'b0;
      for (int i = 0; i < NUM_WIN; i++) active_bank[i] <= '0;
    end else if (copy_now) begin
      cfg_busy <= 1'b0;
      for (int i = 0; i < NUM_WIN; i++) active_bank[i] <= shadow_bank[i];
    end else if (cfg_commit && !cfg_busy) begin
      cfg_busy <= 1'b1;
    end
  end

  always_comb begin
    match_vec = '0;
    for (int i = 0; i < NUM_WIN; i++) begin
      match_vec[i] = active_bank[i].attr[ATTR_EN] &&
                     ((SNES_ADDR & active_bank[i].mask) ==
                      (active_bank[i].base & active_bank[i].mask));
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_match <= '0;
    end else begin
      s1_valid <= SNES_ADDR_VALID;
      if (SNES_ADDR_VALID) begin
        s1_addr  <= SNES_ADDR;
        s1_match <= match_vec;
      end
    end
  end

  addr_window_prio #(
    .NUM_WIN (NUM_WIN),
    .WIN_W   (WIN_W)
  ) u_prio (
    .match_vec (s1_match),
    .hit       (prio_hit),
    .idx       (prio_idx)
  );

  assign win_sel   = active_bank[prio_idx];
  assign xlat_addr = win_sel.offset + (s1_addr & ~win_sel.mask);

  // Outputs only move on a completed lookup; otherwise they hold.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_valid   <= 1'b0;
      ROM_HIT     <= 1'b0;
      ROM_ADDR    <= '0;
      IS_ROM      <= 1'b0;
      IS_SAVERAM  <= 1'b0;
      IS_WRITABLE <= 1'b0;
      win_idx     <= '0;
      miss_count  <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        ROM_HIT <= prio_hit;
        if (prio_hit) begin
          ROM_ADDR    <= xlat_addr;
          IS_ROM      <= win_sel.attr[ATTR_ROM];
          IS_SAVERAM  <= win_sel.attr[ATTR_SRAM];
          IS_WRITABLE <= win_sel.attr[ATTR_WR];
          win_idx     <= prio_idx;
        end else begin
          ROM_ADDR    <= '0;
          IS_ROM      <= 1'b0;
          IS_SAVERAM  <= 1'b0;
          IS_WRITABLE <= 1'b0;
          win_idx     <= '0;
          if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_addr_window_map.sv
// Directed self-checking bench for addr_window_map: window programming,
// priority, wrap-around, deferred commit, miss saturation and reset.
module tb_addr_window_map;

  logic        CLK;
  logic        RST_N;
  logic        cfg_we;
  logic [3:0]  cfg_sel;
  logic [1:0]  cfg_field;
  logic [23:0] cfg_data;
  logic        cfg_commit;
  logic        cfg_busy;
  logic        SNES_ADDR_VALID;
  logic [23:0] SNES_ADDR;
  logic [23:0] ROM_ADDR;
  logic        ROM_HIT;
  logic        IS_ROM;
  logic        IS_SAVERAM;
  logic        IS_WRITABLE;
  logic [2:0]  win_idx;
  logic        out_valid;
  logic [15:0] miss_count;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  addr_window_map #(.NUM_WIN(8), .ADDR_W(24)) dut (
    .CLK             (CLK),
    .RST_N           (RST_N),
    .cfg_we          (cfg_we),
    .cfg_sel         (cfg_sel),
    .cfg_field       (cfg_field),
    .cfg_data        (cfg_data),
    .cfg_commit      (cfg_commit),
    .cfg_busy        (cfg_busy),
    .SNES_ADDR_VALID (SNES_ADDR_VALID),
    .SNES_ADDR       (SNES_ADDR),
    .ROM_ADDR        (ROM_ADDR),
    .ROM_HIT         (ROM_HIT),
    .IS_ROM          (IS_ROM),
    .IS_SAVERAM      (IS_SAVERAM),
    .IS_WRITABLE     (IS_WRITABLE),
    .win_idx         (win_idx),
    .out_valid       (out_valid),
    .miss_count      (miss_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One lookup; returns at the negedge where out_valid should be high.
  task automatic applyStimulus(input logic [23:0] addr);
    @(negedge CLK);
    SNES_ADDR_VALID = 1'b1;
    SNES_ADDR       = addr;
    @(negedge CLK);
    SNES_ADDR_VALID = 1'b0;
    @(negedge CLK);
  endtask

  task automatic cfgWrite(input logic [3:0] sel, input logic [1:0] field,
                          input logic [23:0] data);
    @(negedge CLK);
    cfg_we    = 1'b1;
    cfg_sel   = sel;
    cfg_field = field;
    cfg_data  = data;
    @(negedge CLK);
    cfg_we = 1'b0;
  endtask

  task automatic cfgCommit();
    @(negedge CLK);
    cfg_commit = 1'b1;
    @(negedge CLK);
    cfg_commit = 1'b0;
    for (int i = 0; i < 10 && cfg_busy; i++) @(negedge CLK);
    checkOutput("commit_done", 32'(cfg_busy), 32'h0);
  endtask

  initial begin
    RST_N           = 1'b0;
    cfg_we          = 1'b0;
    cfg_sel         = '0;
    cfg_field       = '0;
    cfg_data        = '0;
    cfg_commit      = 1'b0;
    SNES_ADDR_VALID = 1'b0;
    SNES_ADDR       = '0;
    repeat (2) @(negedge CLK);
    checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_hit", 32'(ROM_HIT), 32'h0);
    checkOutput("rst_addr", 32'(ROM_ADDR), 32'h0);
    checkOutput("rst_busy", 32'(cfg_busy), 32'h0);
    checkOutput("rst_miss", 32'(miss_count), 32'h0);
    checkOutput("rst_idx", 32'(win_idx), 32'h0);
    RST_N = 1'b1;

    applyStimulus(24'h008000);
    checkOutput("miss1_valid", 32'(out_valid), 32'h1);
    checkOutput("miss1_hit", 32'(ROM_HIT), 32'h0);
    checkOutput("miss1_addr", 32'(ROM_ADDR), 32'h0);
    checkOutput("miss1_count", 32'(miss_count), 32'h1);
    @(negedge CLK);
    checkOutput("valid_strobe", 32'(out_valid), 32'h0);

    cfgWrite(4'd0, 2'd0, 24'hC00000);
    cfgWrite(4'd0, 2'd1, 24'hC00000);
    cfgWrite(4'd0, 2'd2, 24'h000000);
    cfgWrite(4'd0, 2'd3, 24'h000003);
    // Out-of-range select must not alias onto window 0.
    cfgWrite(4'd8, 2'd3, 24'h000000);
    @(negedge CLK);
    cfg_commit = 1'b1;
    @(negedge CLK);
    cfg_commit = 1'b0;
    checkOutput("busy_raised", 32'(cfg_busy), 32'h1);
    for (int i = 0; i < 10 && cfg_busy; i++) @(negedge CLK);
    checkOutput("busy_cleared", 32'(cfg_busy), 32'h0);

    applyStimulus(24'hC12345);
    checkOutput("w0_hit", 32'(ROM_HIT), 32'h1);
    checkOutput("w0_addr", 32'(ROM_ADDR), 32'h012345);
    checkOutput("w0_rom", 32'(IS_ROM), 32'h1);
    checkOutput("w0_sram", 32'(IS_SAVERAM), 32'h0);
    checkOutput("w0_idx", 32'(win_idx), 32'h0);

    cfgWrite(4'd1, 2'd0, 24'h708000);
    cfgWrite(4'd1, 2'd1, 24'hFF8000);
    cfgWrite(4'd1, 2'd2, 24'hE00000);
    cfgWrite(4'd1, 2'd3, 24'h00000D);
    cfgWrite(4'd3, 2'd0, 24'h700000);
    cfgWrite(4'd3, 2'd1, 24'hF00000);
    cfgWrite(4'd3, 2'd2, 24'h100000);
    cfgWrite(4'd3, 2'd3, 24'h000003);
    cfgWrite(4'd2, 2'd0, 24'h200000);
    cfgWrite(4'd2, 2'd1, 24'hFFF000);
    cfgWrite(4'd2, 2'd2, 24'hFFFF00);
    cfgWrite(4'd2, 2'd3, 24'h000003);

    applyStimulus(24'h70ABCD);
    checkOutput("pre_commit_miss", 32'(ROM_HIT), 32'h0);
    checkOutput("pre_commit_count", 32'(miss_count), 32'h2);
    cfgCommit();

    applyStimulus(24'h70ABCD);
    checkOutput("prio_idx", 32'(win_idx), 32'h1);
    checkOutput("prio_addr", 32'(ROM_ADDR), 32'hE02BCD);
    checkOutput("prio_rom", 32'(IS_ROM), 32'h0);
    checkOutput("prio_sram", 32'(IS_SAVERAM), 32'h1);
    checkOutput("prio_wr", 32'(IS_WRITABLE), 32'h1);

    applyStimulus(24'h7F0000);
    checkOutput("w3_idx", 32'(win_idx), 32'h3);
    checkOutput("w3_addr", 32'(ROM_ADDR), 32'h1F0000);
    checkOutput("w3_rom", 32'(IS_ROM), 32'h1);

    applyStimulus(24'h200200);
    checkOutput("wrap_idx", 32'(win_idx), 32'h2);
    checkOutput("wrap_addr", 32'(ROM_ADDR), 32'h000100);

    // Deferred commit: a continuous burst keeps the old window 0 mapping.
    cfgWrite(4'd0, 2'd2, 24'h300000);
    @(negedge CLK);
    SNES_ADDR_VALID = 1'b1;
    SNES_ADDR       = 24'hC12345;
    cfg_commit      = 1'b1;
    @(negedge CLK);
    cfg_commit = 1'b0;
    checkOutput("burst_busy", 32'(cfg_busy), 32'h1);
    cfg_we    = 1'b1;
    cfg_sel   = 4'd0;
    cfg_field = 2'd2;
    cfg_data  = 24'h500000;
    @(negedge CLK);
    cfg_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checkOutput("burst_valid", 32'(out_valid), 32'h1);
      checkOutput("burst_old_addr", 32'(ROM_ADDR), 32'h012345);
      checkOutput("burst_still_busy", 32'(cfg_busy), 32'h1);
      @(negedge CLK);
    end
    SNES_ADDR_VALID = 1'b0;
    for (int i = 0; i < 10 && cfg_busy; i++) @(negedge CLK);
    checkOutput("burst_busy_clear", 32'(cfg_busy), 32'h0);
    applyStimulus(24'hC12345);
    checkOutput("burst_new_addr", 32'(ROM_ADDR), 32'h312345);

    // Miss saturation: 65536 more misses on top of the two already counted.
    @(negedge CLK);
    SNES_ADDR_VALID = 1'b1;
    SNES_ADDR       = 24'h000000;
    repeat (65536) @(negedge CLK);
    SNES_ADDR_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    checkOutput("miss_saturate", 32'(miss_count), 32'h0000FFFF);
    checkOutput("miss_sat_hit", 32'(ROM_HIT), 32'h0);

    // Reset while a lookup is in stage 1.
    @(negedge CLK);
    SNES_ADDR_VALID = 1'b1;
    SNES_ADDR       = 24'h000000;
    @(negedge CLK);
    SNES_ADDR_VALID = 1'b0;
    #2 RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checkOutput("rst_mid_valid", 32'(out_valid), 32'h0);
      @(negedge CLK);
    end
    checkOutput("rst_mid_miss", 32'(miss_count), 32'h0);
    applyStimulus(24'hC12345);
    checkOutput("rst_windows_cleared", 32'(ROM_HIT), 32'h0);
    checkOutput("rst_miss_restart", 32'(miss_count), 32'h1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
